timer_ctrl_mmss: RTL

- Parametrised successor of the single-channel timer FSM: FSM and MM:SS counter merged into one block.
- Supports set, count-up or count-down, pause, clear and an expiry (DONE) state with alarm outputs.
- Sits between the debounced button/edge-detect logic and the VGA digit renderer; consumes a 1-cycle `tick` enable from the prescaler.

---
 rtl/timer_ctrl_mmss.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_mmss.sv
// MM:SS timer with set / run (up or down) / pause / clear / done control.
// Define TIMER_AUTORELOAD_EN to make down-counting reload the preset instead of expiring.
module timer_ctrl_mmss #(
  parameter int unsigned SEC_W   = 6,
  parameter int unsigned MIN_W   = 7,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             delete,
  input  logic             sec_up,
  input  logic             min_up,
  input  logic             count_down,
  output logic [SEC_W-1:0] sec_o,
  output logic [MIN_W-1:0] min_o,
  output logic [2:0]       state_o,
  output logic             running,
  output logic             done,
  output logic             done_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
  localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic             dir_q, dir_d;
  logic             running_q, done_q, pulse_q, pulse_d;
  logic             is_zero, expire;
`ifdef TIMER_AUTORELOAD_EN
  logic [MIN_W+SEC_W-1:0] preset_q, preset_d;
`endif

  function automatic logic [SEC_W-1:0] sec_inc(input logic [SEC_W-1:0] s);
    return (s == SEC_LAST) ? '0 : s + SEC_ONE;
  endfunction

  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
    return (m == MIN_LAST) ? '0 : m + MIN_ONE;
  endfunction

  assign is_zero = (sec_q == '0) && (min_q == '0);
  // A down tick from 00:01 (or a down run started at 00:00 from SET) lands on 00:00.
  assign expire  = (min_q == '0) && (sec_q <= SEC_ONE);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    preset_d = preset_q;
`endif
    case (state_q)
      ST_IDLE, ST_SET: begin
        if (delete) begin
          state_d = ST_CLEAR;
        end else if (start && !(state_q == ST_IDLE && count_down && is_zero)) begin
          state_d = ST_RUN;
          dir_d   = count_down;
`ifdef TIMER_AUTORELOAD_EN
          preset_d = {min_q, sec_q};
`endif
        end else if (sec_up || min_up) begin
          state_d = ST_SET;
          if (sec_up) sec_d = sec_inc(sec_q);
          if (min_up) min_d = min_inc(min_q);
        end
      end
      ST_RUN: begin
        if (delete) begin
          state_d = ST_CLEAR;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (!dir_q) begin
            if (sec_q == SEC_LAST && min_q == MIN_LAST) begin
              state_d = ST_DONE;
              pulse_d = 1'b1;
            end else if (sec_q == SEC_LAST) begin
              sec_d = '0;
              min_d = min_q + MIN_ONE;
            end else begin
              sec_d = sec_q + SEC_ONE;
            end
          end else if (expire) begin
`ifdef TIMER_AUTORELOAD_EN
            {min_d, sec_d} = preset_q;
            pulse_d        = 1'b1;
`else
            sec_d   = '0;
            min_d   = '0;
            state_d = ST_DONE;
            pulse_d = 1'b1;
`endif
          end else if (sec_q == '0) begin
            sec_d = SEC_LAST;
            min_d = min_q - MIN_ONE;
          end else begin
            sec_d = sec_q - SEC_ONE;
          end
        end
      end
      ST_PAUSE: begin
        if (delete)     state_d = ST_CLEAR;
        else if (start) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (delete) state_d = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
    if (state_d == ST_CLEAR) begin
      sec_d = '0;
      min_d = '0;
    end
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sec_q     <= '0;
      min_q     <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      preset_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      dir_q     <= dir_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      pulse_q   <= pulse_d;
`ifdef TIMER_AUTORELOAD_EN
      preset_q  <= preset_d;
`endif
    end
  end

  assign sec_o      = sec_q;
  assign min_o      = min_q;
  assign state_o    = state_q;
  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = pulse_q;

endmodule
